// File: rtl/param_shift_register_pkg.sv
// Shared encodings for the parametrised multi-function shift register:
// shift modes, shift direction and the control FSM states.
package param_shift_register_pkg;

  localparam logic [1:0] MODE_LOGIC = 2'b00;
  localparam logic [1:0] MODE_ROT   = 2'b01;
  localparam logic [1:0] MODE_ARITH = 2'b10;

  typedef enum logic {
    DIR_RIGHT = 1'b0,
    DIR_LEFT  = 1'b1
  } dir_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/param_shift_register_shift_step.sv
// Combinational single-bit shifter: one step of a right/left shift in
// logical (serial fill), rotate or arithmetic mode, plus the bit shifted out.
module shift_step
  import param_shift_register_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value_i,
  input  dir_t             dir_i,
  input  logic [1:0]       mode_i,
  input  logic             fill_i,
  output logic [WIDTH-1:0] value_o,
  output logic             bit_o
);

  always_comb begin
    value_o = value_i;
    bit_o   = 1'b0;
    if (dir_i == DIR_LEFT) begin
      bit_o = value_i[WIDTH-1];
      case (mode_i)
        MODE_ROT:   value_o = {value_i[WIDTH-2:0], value_i[WIDTH-1]};
        MODE_ARITH: value_o = {value_i[WIDTH-2:0], 1'b0};
        default:    value_o = {value_i[WIDTH-2:0], fill_i};
      endcase
    end else begin
      bit_o = value_i[0];
      case (mode_i)
        MODE_ROT:   value_o = {value_i[0], value_i[WIDTH-1:1]};
        MODE_ARITH: value_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
        default:    value_o = {fill_i, value_i[WIDTH-1:1]};
      endcase
    end
  end

endmodule

// File: rtl/param_shift_register.sv
// WIDTH-bit register with clear/load/inc/dec and multi-cycle shifts, one bit
// per cycle under a two-state FSM; optional saturating inc/dec.
module param_shift_register
  import param_shift_register_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  bit SAT   = 1'b0,
  localparam int SHW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cl,
  input  logic             ld,
  input  logic [WIDTH-1:0] in,
  input  logic             inc,
  input  logic             dec,
  input  logic             sr,
  input  logic             sl,
  input  logic             ir,
  input  logic             il,
  input  logic [1:0]       mode,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam logic [SHW-1:0] MAX_SH = SHW'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             carry_q, carry_d;
  logic             done_q, done_d;
  logic [SHW-1:0]   count_q, count_d;
  dir_t             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;

  logic [WIDTH-1:0] step_value;
  logic             step_bit;
  logic             step_fill;

  // Serial fill is sampled live each shift cycle so streaming works.
  assign step_fill = (dir_q == DIR_LEFT) ? il : ir;

  shift_step #(.WIDTH(WIDTH)) u_step (
    .value_i (out_q),
    .dir_i   (dir_q),
    .mode_i  (mode_q),
    .fill_i  (step_fill),
    .value_o (step_value),
    .bit_o   (step_bit)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    carry_d = carry_q;
    count_d = count_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cl) begin
          out_d   = '0;
          carry_d = 1'b0;
        end else if (ld) begin
          out_d   = in;
          carry_d = 1'b0;
        end else if (inc) begin
          // carry flags the all-ones case in both wrap and saturate modes
          carry_d = &out_q;
          if (!(SAT && (&out_q))) out_d = out_q + 1'b1;
        end else if (dec) begin
          carry_d = ~|out_q;
          if (!(SAT && !(|out_q))) out_d = out_q - 1'b1;
        end else if ((sr || sl) && (shamt != '0)) begin
          dir_d   = sr ? DIR_RIGHT : DIR_LEFT;
          mode_d  = mode;
          count_d = (shamt > MAX_SH) ? MAX_SH : shamt;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cl) begin
          out_d   = '0;
          carry_d = 1'b0;
          count_d = '0;
          state_d = ST_IDLE;
        end else begin
          out_d   = step_value;
          carry_d = step_bit;
          count_d = count_q - 1'b1;
          if (count_q == SHW'(1)) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      out_q   <= '0;
      carry_q <= 1'b0;
      done_q  <= 1'b0;
      count_q <= '0;
      dir_q   <= DIR_RIGHT;
      mode_q  <= MODE_LOGIC;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      carry_q <= carry_d;
      done_q  <= done_d;
      count_q <= count_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
    end
  end

  assign out   = out_q;
  assign carry = carry_q;
  assign zero  = (out_q == '0);
  assign busy  = (state_q == ST_SHIFT);
  assign done  = done_q;

endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register: a wrapping (SAT=0) and a saturating (SAT=1)
// instance share stimulus; shift results are scored against a queue.
module tb_param_shift_register;

  logic       clk = 1'b0;
  logic       rst, cl, ld, inc, dec, sr, sl, ir, il;
  logic [1:0] mode;
  logic [3:0] shamt;
  logic [7:0] din;

  logic [7:0] out0, out1;
  logic       carry0, zero0, busy0, done0;
  logic       carry1, zero1, busy1, done1;

  typedef struct packed {
    logic [7:0] out;
    logic       carry;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  param_shift_register #(.WIDTH(8), .SAT(1'b0)) dut0 (
    .clk(clk), .rst(rst), .cl(cl), .ld(ld), .in(din), .inc(inc), .dec(dec),
    .sr(sr), .sl(sl), .ir(ir), .il(il), .mode(mode), .shamt(shamt),
    .out(out0), .carry(carry0), .zero(zero0), .busy(busy0), .done(done0)
  );

  param_shift_register #(.WIDTH(8), .SAT(1'b1)) dut1 (
    .clk(clk), .rst(rst), .cl(cl), .ld(ld), .in(din), .inc(inc), .dec(dec),
    .sr(sr), .sl(sl), .ir(ir), .il(il), .mode(mode), .shamt(shamt),
    .out(out1), .carry(carry1), .zero(zero1), .busy(busy1), .done(done1)
  );

  // Reference single-bit shift: returns {shifted_out_bit, new_value}.
  function automatic logic [8:0] ref_step(input logic [7:0] v, input logic left,
                                          input logic [1:0] m, input logic fill);
    logic [7:0] r;
    logic       b;
    if (left) begin
      b = v[7];
      r = v << 1;
      if (m == 2'b01) r[0] = v[7];
      else if (m == 2'b10) r[0] = 1'b0;
      else r[0] = fill;
    end else begin
      b = v[0];
      r = v >> 1;
      if (m == 2'b01) r[7] = v[0];
      else if (m == 2'b10) r[7] = v[7];
      else r[7] = fill;
    end
    return {b, r};
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cl = 0; ld = 0; inc = 0; dec = 0; sr = 0; sl = 0;
    ir = 0; il = 0; mode = 2'b00; shamt = 4'd0; din = 8'h00;
  endtask

  task automatic load(input logic [7:0] v);
    ld = 1; din = v;
    tick();
    ld = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int i = 0; i < 2; i++) begin
      {cl, ld, inc, dec, sr, sl, ir, il} = 8'($urandom);
      mode = 2'($urandom); shamt = 4'($urandom); din = 8'($urandom);
      tick();
    end
    vectors++;
    if ({out0, carry0, busy0, done0, zero0} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_sat0: got out=%h carry=%b busy=%b done=%b zero=%b, expected 00 0 0 0 1",
               out0, carry0, busy0, done0, zero0);
    end
    vectors++;
    if ({out1, carry1, busy1, done1, zero1} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_sat1: got out=%h carry=%b busy=%b done=%b zero=%b, expected 00 0 0 0 1",
               out1, carry1, busy1, done1, zero1);
    end
    rst = 0;
    idle_inputs();
    $display("reset: out=%h carry=%b busy=%b done=%b zero=%b", out0, carry0, busy0, done0, zero0);
  endtask

  task automatic test_inc_dec();
    load(8'hFF);
    inc = 1; tick(); inc = 0;
    vectors++;
    if ({out0, carry0, zero0} !== {8'h00, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL inc_wrap: got out=%h carry=%b zero=%b, expected 00 1 1", out0, carry0, zero0);
    end
    vectors++;
    if ({out1, carry1, zero1} !== {8'hFF, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL inc_sat: got out=%h carry=%b zero=%b, expected ff 1 0", out1, carry1, zero1);
    end
    $display("inc from ff: wrap out=%h c=%b, sat out=%h c=%b", out0, carry0, out1, carry1);
    cl = 1; tick(); cl = 0;
    dec = 1; tick(); dec = 0;
    vectors++;
    if ({out0, carry0} !== {8'hFF, 1'b1}) begin
      miscompares++;
      $display("FAIL dec_wrap: got out=%h carry=%b, expected ff 1", out0, carry0);
    end
    vectors++;
    if ({out1, carry1, zero1} !== {8'h00, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL dec_sat: got out=%h carry=%b zero=%b, expected 00 1 1", out1, carry1, zero1);
    end
    $display("dec from 00: wrap out=%h c=%b, sat out=%h c=%b", out0, carry0, out1, carry1);
    load(8'h41);
    inc = 1; tick(); inc = 0;
    dec = 1; tick(); dec = 0;
    dec = 1; tick(); dec = 0;
    vectors++;
    if ({out0, carry0, out1, carry1} !== {8'h40, 1'b0, 8'h40, 1'b0}) begin
      miscompares++;
      $display("FAIL inc_dec_mid: got out=%h/%h carry=%b/%b, expected 40/40 0/0",
               out0, out1, carry0, carry1);
    end
    $display("0x41 +1 -1 -1: out=%h carry=%b", out0, carry0);
  endtask

  task automatic test_arith_shift();
    logic [7:0] v;
    logic       c;
    logic [8:0] r;
    exp_t       e;
    int         n;
    load(8'h81);
    v = 8'h81; c = 1'b0;
    sb.push_back(exp_t'{v, c, 1'b1, 1'b0});
    for (int i = 0; i < 3; i++) begin
      r = ref_step(v, 1'b0, 2'b10, 1'b0);
      {c, v} = r;
      sb.push_back(exp_t'{v, c, (i < 2), (i == 2)});
    end
    sb.push_back(exp_t'{v, c, 1'b0, 1'b0});
    sr = 1; mode = 2'b10; shamt = 4'd3;
    n = sb.size();
    for (int k = 0; k < n; k++) begin
      tick();
      sr = 0;
      e = sb.pop_front();
      vectors++;
      if ({out0, carry0, busy0, done0} !== e) begin
        miscompares++;
        $display("FAIL arith_sr cyc%0d: got out=%h c=%b busy=%b done=%b, expected out=%h c=%b busy=%b done=%b",
                 k, out0, carry0, busy0, done0, e.out, e.carry, e.busy, e.done);
      end
      $display("arith sr cyc%0d: out=%h carry=%b busy=%b done=%b", k, out0, carry0, busy0, done0);
    end
    vectors++;
    if ({out0, carry0} !== {8'hF0, 1'b0}) begin
      miscompares++;
      $display("FAIL arith_sr_final: got out=%h carry=%b, expected f0 0", out0, carry0);
    end
    idle_inputs();
  endtask

  // Rotate by 8, then a second command (shamt=15, clamped) issued in the done cycle.
  task automatic test_back_to_back();
    logic [7:0] v;
    logic       c;
    logic [8:0] r;
    exp_t       e;
    int         idx;
    load(8'hA5);
    v = 8'hA5; c = 1'b0;
    for (int k = 0; k < 19; k++) begin
      idx = (k < 9) ? k : k - 9;
      if (k == 0 || k == 9) begin
        sb.push_back(exp_t'{v, c, 1'b1, 1'b0});
      end else if (k == 18) begin
        sb.push_back(exp_t'{v, c, 1'b0, 1'b0});
      end else begin
        r = ref_step(v, 1'b1, 2'b01, 1'b0);
        {c, v} = r;
        sb.push_back(exp_t'{v, c, (idx < 8), (idx == 8)});
      end
    end
    mode = 2'b01;
    for (int k = 0; k < 19; k++) begin
      sl = (k == 0 || k == 9);
      shamt = (k == 0) ? 4'd8 : 4'd15;
      tick();
      e = sb.pop_front();
      vectors++;
      if ({out0, carry0, busy0, done0} !== e) begin
        miscompares++;
        $display("FAIL rot_sl cyc%0d: got out=%h c=%b busy=%b done=%b, expected out=%h c=%b busy=%b done=%b",
                 k, out0, carry0, busy0, done0, e.out, e.carry, e.busy, e.done);
      end
      $display("rot sl cyc%0d: out=%h carry=%b busy=%b done=%b", k, out0, carry0, busy0, done0);
    end
    vectors++;
    if ({out0, carry0} !== {8'hA5, 1'b1}) begin
      miscompares++;
      $display("FAIL rot_sl_final: got out=%h carry=%b, expected a5 1", out0, carry0);
    end
    idle_inputs();
  endtask

  // Logical left shift with il changing every busy cycle.
  task automatic test_serial_stream();
    logic [7:0] v;
    logic       c;
    logic [8:0] r;
    logic [4:0] bits;
    exp_t       e;
    bits = 5'($urandom);
    load(8'h96);
    v = 8'h96; c = 1'b0;
    sb.push_back(exp_t'{v, c, 1'b1, 1'b0});
    for (int i = 1; i <= 4; i++) begin
      r = ref_step(v, 1'b1, 2'b11, bits[i]);
      {c, v} = r;
      sb.push_back(exp_t'{v, c, (i < 4), (i == 4)});
    end
    mode = 2'b11;
    for (int k = 0; k < 5; k++) begin
      sl = (k == 0);
      shamt = 4'd4;
      il = bits[k];
      tick();
      e = sb.pop_front();
      vectors++;
      if ({out0, carry0, busy0, done0} !== e) begin
        miscompares++;
        $display("FAIL stream_sl cyc%0d: got out=%h c=%b busy=%b done=%b, expected out=%h c=%b busy=%b done=%b",
                 k, out0, carry0, busy0, done0, e.out, e.carry, e.busy, e.done);
      end
      $display("stream sl cyc%0d il=%b: out=%h carry=%b busy=%b done=%b", k, il, out0, carry0, busy0, done0);
    end
    idle_inputs();
  endtask

  task automatic test_abort();
    exp_t e;
    load(8'h3C);
    sb.push_back(exp_t'{8'h3C, 1'b0, 1'b1, 1'b0});
    sb.push_back(exp_t'{8'h1E, 1'b0, 1'b1, 1'b0});
    sb.push_back(exp_t'{8'h00, 1'b0, 1'b0, 1'b0});
    sb.push_back(exp_t'{8'h00, 1'b0, 1'b0, 1'b0});
    mode = 2'b00; shamt = 4'd5; ir = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sr  = (k == 0);
      inc = (k == 1);
      cl  = (k == 2);
      tick();
      e = sb.pop_front();
      vectors++;
      if ({out0, carry0, busy0, done0} !== e) begin
        miscompares++;
        $display("FAIL abort cyc%0d: got out=%h c=%b busy=%b done=%b, expected out=%h c=%b busy=%b done=%b",
                 k, out0, carry0, busy0, done0, e.out, e.carry, e.busy, e.done);
      end
      $display("abort cyc%0d: out=%h carry=%b busy=%b done=%b", k, out0, carry0, busy0, done0);
    end
    idle_inputs();
  endtask

  task automatic test_priority_and_noop();
    ld = 1; inc = 1; din = 8'h10;
    tick();
    idle_inputs();
    vectors++;
    if ({out0, carry0} !== {8'h10, 1'b0}) begin
      miscompares++;
      $display("FAIL ld_over_inc: got out=%h carry=%b, expected 10 0", out0, carry0);
    end
    $display("ld+inc in=10: out=%h", out0);
    for (int k = 0; k < 3; k++) begin
      sr = (k == 0); shamt = 4'd0;
      tick();
      vectors++;
      if ({out0, busy0, done0} !== {8'h10, 1'b0, 1'b0}) begin
        miscompares++;
        $display("FAIL shamt0 cyc%0d: got out=%h busy=%b done=%b, expected 10 0 0",
                 k, out0, busy0, done0);
      end
      $display("sr shamt=0 cyc%0d: out=%h busy=%b done=%b", k, out0, busy0, done0);
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_inc_dec();
    test_arith_shift();
    test_back_to_back();
    test_serial_stream();
    test_abort();
    test_priority_and_noop();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
